shift_exec_stage: RTL and testbench

- Execute-stage slot for RV32 shift instructions (SLL/SRL/SRA and immediate forms), between the issue/decode stage and the writeback arbiter.
- Accepts one shift op per cycle over a valid/ready handshake and computes the result combinationally on acceptance.
- Registers the result with its destination tag in a 2-entry skid buffer so writeback back-pressure never creates a combinational ready path to issue.
- Supports a pipeline flush from branch/exception redirect.

---
 rtl/shift_exec_if.sv | 28 ++
 rtl/shift_exec_stage.sv | 84 ++++++++
 tb/tb_shift_exec_stage.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_exec_if.sv
// Handshake bundle between issue, the shift execute slot and the writeback arbiter.
// master = issue/writeback side, slave = the execute stage.
interface shift_exec_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [4:0]       in_shamt;
  logic [TAG_W-1:0] in_rd;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_data;
  logic [TAG_W-1:0] out_rd;
  logic             out_illegal;

  modport master (
    output in_valid, in_op, in_a, in_shamt, in_rd, out_ready,
    input  in_ready, out_valid, out_data, out_rd, out_illegal
  );

  modport slave (
    input  in_valid, in_op, in_a, in_shamt, in_rd, out_ready,
    output in_ready, out_valid, out_data, out_rd, out_illegal
  );
endinterface

// File: rtl/shift_exec_stage.sv
// RV32 shift execute slot: computes SLL/SRL/SRA on acceptance and holds results in a
// main/skid pair so writeback stalls never reach issue combinationally.
module shift_exec_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  shift_exec_if.slave   bus
);

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  data;
    logic [TAG_W-1:0] rd;
    logic             illegal;
  } entry_t;

  entry_t r_main;
  entry_t r_skid;
  entry_t w_new;
  logic   w_in_ready;
  logic   w_accept;
  logic   w_main_free;

  // Returns {illegal, result}; reserved encoding passes the operand through.
  function automatic logic [XLEN:0] shift_calc(input logic [1:0]      op,
                                               input logic [XLEN-1:0] a,
                                               input logic [4:0]      sh);
    logic [XLEN:0] res;
    case (op)
      2'b00:   res = {1'b0, a << sh};
      2'b01:   res = {1'b0, a >> sh};
      2'b11:   res = {1'b0, XLEN'($signed(a) >>> sh)};
      default: res = {1'b1, a};
    endcase
    return res;
  endfunction

  assign w_in_ready  = rst_n & ~r_skid.valid;
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_main_free = ~r_main.valid | bus.out_ready;

  // Build the buffer entry for the op presented this cycle.
  always_comb begin
    w_new       = '0;
    w_new.valid = 1'b1;
    w_new.rd    = bus.in_rd;
    {w_new.illegal, w_new.data} = shift_calc(bus.in_op, bus.in_a, bus.in_shamt);
  end

  // Main/skid buffer update; flush beats any move or accept in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else if (flush) begin
      r_main.valid <= 1'b0;
      r_skid.valid <= 1'b0;
    end else if (w_main_free) begin
      // in_ready is low whenever skid is valid, so a skid move never races an accept
      if (r_skid.valid) begin
        r_main       <= r_skid;
        r_skid.valid <= 1'b0;
      end else if (w_accept) begin
        r_main <= w_new;
      end else begin
        r_main.valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid <= w_new;
    end else begin
      r_skid <= r_skid;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_main.valid;
  assign bus.out_data    = r_main.data;
  assign bus.out_rd      = r_main.rd;
  assign bus.out_illegal = r_main.illegal;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed bench for shift_exec_stage: an in-order 2-deep result queue model checked
// every cycle, plus literal expectations that pin both the DUT and the model.
module tb_shift_exec_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  shift_exec_if bus ();

  shift_exec_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   nerr = 0;
  int   nchk = 0;

  logic        lit_en  = 1'b0;
  logic        lit_v   = 1'b0;
  logic [31:0] lit_d   = 32'h0;
  logic [4:0]  lit_rd  = 5'h0;
  logic        lit_ill = 1'b0;
  logic        lit_rdy = 1'b0;

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a,
                                 input logic [4:0] sh, input logic [4:0] rd);
    exp_t e;
    longint unsigned p;
    longint unsigned av;
    p     = 64'd1 << sh;
    av    = {32'd0, a};
    e.rd  = rd;
    e.ill = 1'b0;
    case (op)
      2'b00: e.d = 32'((av * p) % 64'h1_0000_0000);
      2'b01: e.d = 32'(av / p);
      2'b11: e.d = a[31] ? ~32'({32'd0, ~a} / p) : 32'(av / p);
      default: begin e.d = a; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  // Behavioural model: ops enter an in-order queue of at most two results.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      bit acc;
      bit xf;
      acc = bus.in_valid && (q.size() < 2);
      xf  = (q.size() > 0) && bus.out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (xf) void'(q.pop_front());
        if (acc) q.push_back(model(bus.in_op, bus.in_a, bus.in_shamt, bus.in_rd));
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Single compare process: model vs DUT each cycle, plus pinned literals.
  always begin
    @(posedge clk or negedge rst_n);
    #2;
    if (!rst_n) begin
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_out_data", bus.out_data, 32'd0);
      chk("rst_out_rd", 32'(bus.out_rd), 32'd0);
      chk("rst_out_illegal", 32'(bus.out_illegal), 32'd0);
    end else begin
      chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
      if (q.size() != 0) begin
        chk("out_data", bus.out_data, q[0].d);
        chk("out_rd", 32'(bus.out_rd), 32'(q[0].rd));
        chk("out_illegal", 32'(bus.out_illegal), 32'(q[0].ill));
      end
    end
    if (lit_en) begin
      chk("lit_valid", 32'(bus.out_valid), 32'(lit_v));
      chk("lit_ready", 32'(bus.in_ready), 32'(lit_rdy));
      chk("lit_model_valid", 32'(q.size() != 0), 32'(lit_v));
      if (lit_v || !rst_n) begin
        chk("lit_data", bus.out_data, lit_d);
        chk("lit_rd", 32'(bus.out_rd), 32'(lit_rd));
        chk("lit_illegal", 32'(bus.out_illegal), 32'(lit_ill));
      end
      if (lit_v && q.size() != 0) begin
        chk("lit_model_data", q[0].d, lit_d);
        chk("lit_model_illegal", 32'(q[0].ill), 32'(lit_ill));
      end
    end
  end

  task automatic put(input logic v, input logic [1:0] op, input logic [31:0] a,
                     input logic [4:0] sh, input logic [4:0] rd);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_shamt = sh;
    bus.in_rd    = rd;
  endtask

  task automatic pin_now(input logic v, input logic [31:0] d, input logic [4:0] rd,
                         input logic ill, input logic rdy);
    #1;
    lit_v   = v;
    lit_d   = d;
    lit_rd  = rd;
    lit_ill = ill;
    lit_rdy = rdy;
    lit_en  = 1'b1;
    #2;
    lit_en  = 1'b0;
  endtask

  task automatic pin(input logic v, input logic [31:0] d, input logic [4:0] rd,
                     input logic ill, input logic rdy);
    @(posedge clk);
    pin_now(v, d, rd, ill, rdy);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  sh;
    logic        ordy;
  } vec_t;

  vec_t vecs[6] = '{
    '{2'b11, 32'h80000000, 5'd31, 1'b1},
    '{2'b01, 32'h80000000, 5'd31, 1'b0},
    '{2'b11, 32'h7FFFFFF0, 5'd4,  1'b0},
    '{2'b00, 32'hA5A5A5A5, 5'd16, 1'b1},
    '{2'b11, 32'hC0000000, 5'd0,  1'b0},
    '{2'b10, 32'h00000001, 5'd7,  1'b1}
  };

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'b00;
    bus.in_a      = 32'h0;
    bus.in_shamt  = 5'd0;
    bus.in_rd     = 5'd0;
    bus.out_ready = 1'b1;

    pin(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    pin(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);

    // SRA sign fill
    put(1'b1, 2'b11, 32'h80000000, 5'd4, 5'd7);
    pin(1'b1, 32'hF8000000, 5'd7, 1'b0, 1'b1);
    put(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
    pin(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);

    // Back-to-back at full rate
    put(1'b1, 2'b01, 32'h80000000, 5'd4, 5'd1);
    pin(1'b1, 32'h08000000, 5'd1, 1'b0, 1'b1);
    put(1'b1, 2'b00, 32'h00000001, 5'd31, 5'd2);
    pin(1'b1, 32'h80000000, 5'd2, 1'b0, 1'b1);
    put(1'b1, 2'b00, 32'h12345678, 5'd0, 5'd3);
    pin(1'b1, 32'h12345678, 5'd3, 1'b0, 1'b1);
    put(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
    pin(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);

    // Back-pressure: third op refused while skid is full
    bus.out_ready = 1'b0;
    put(1'b1, 2'b00, 32'h0000000F, 5'd4, 5'd4);
    pin(1'b1, 32'h000000F0, 5'd4, 1'b0, 1'b1);
    put(1'b1, 2'b01, 32'hF0000000, 5'd8, 5'd5);
    pin(1'b1, 32'h000000F0, 5'd4, 1'b0, 1'b0);
    put(1'b1, 2'b11, 32'h7FFFFFFF, 5'd31, 5'd6);
    pin(1'b1, 32'h000000F0, 5'd4, 1'b0, 1'b0);
    put(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
    bus.out_ready = 1'b1;
    pin(1'b1, 32'h00F00000, 5'd5, 1'b0, 1'b1);
    pin(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);

    // Flush with two buffered and one incoming
    bus.out_ready = 1'b0;
    put(1'b1, 2'b11, 32'h80000001, 5'd1, 5'd9);
    put(1'b1, 2'b00, 32'hFFFFFFFF, 5'd1, 5'd10);
    put(1'b1, 2'b01, 32'hFFFFFFFF, 5'd31, 5'd11);
    flush = 1'b1;
    pin(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
    put(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
    flush = 1'b0;
    bus.out_ready = 1'b1;
    pin(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
    pin(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);

    // Reserved encoding
    put(1'b1, 2'b10, 32'hDEADBEEF, 5'd3, 5'd12);
    pin(1'b1, 32'hDEADBEEF, 5'd12, 1'b1, 1'b1);
    put(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);

    // Mixed table with intermittent writeback stalls
    for (int i = 0; i < 6; i++) begin
      put(1'b1, vecs[i].op, vecs[i].a, vecs[i].sh, 5'(20 + i));
      bus.out_ready = vecs[i].ordy;
    end
    put(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Asynchronous reset while an entry is held
    bus.out_ready = 1'b0;
    put(1'b1, 2'b00, 32'h00000001, 5'd1, 5'd13);
    pin(1'b1, 32'h00000002, 5'd13, 1'b0, 1'b1);
    rst_n = 1'b0;
    pin_now(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pin(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
    pin(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
